// File: rtl/uart_tx_scheduler.sv
// uart_tx_scheduler: round-robin arbiter that shares one uart_tx among
// NUM_REQ requesters. It latches the winner's byte and frame configuration
// and holds them stable from the grant until the frame has fully completed.
module uart_tx_scheduler #(
    parameter int NUM_REQ      = 4,
    parameter int DATA_WIDTH   = 8,
    parameter int BUSY_TIMEOUT = 4096,
    localparam int ID_W        = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
    input  logic [NUM_REQ*5-1:0]          req_cfg,
    output logic [NUM_REQ-1:0]            req_ready,
    output logic                          tx_valid,
    output logic [DATA_WIDTH-1:0]         tx_data,
    output logic                          tx_mode,
    output logic [1:0]                    tx_parity,
    output logic [1:0]                    tx_stop,
    input  logic                          tx_ready,
    output logic [ID_W-1:0]               grant_id,
    output logic                          busy,
    output logic                          timeout_err
);

    localparam int CNT_W = $clog2(BUSY_TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(BUSY_TIMEOUT - 1);

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_SEND      = 2'd1,
        ST_WAIT_BUSY = 2'd2,
        ST_WAIT_DONE = 2'd3
    } state_t;

    state_t                  r_state;
    logic [ID_W-1:0]         r_last;
    logic [CNT_W-1:0]        r_cnt;
    logic [NUM_REQ-1:0]      r_reqReady;
    logic                    r_txValid;
    logic [DATA_WIDTH-1:0]   r_txData;
    logic [4:0]              r_txCfg;
    logic [ID_W-1:0]         r_grantId;
    logic                    r_busy;
    logic                    r_timeoutErr;

    state_t                  w_stateNxt;
    logic [ID_W-1:0]         w_lastNxt;
    logic [CNT_W-1:0]        w_cntNxt;
    logic [NUM_REQ-1:0]      w_reqReadyNxt;
    logic                    w_txValidNxt;
    logic [DATA_WIDTH-1:0]   w_txDataNxt;
    logic [4:0]              w_txCfgNxt;
    logic [ID_W-1:0]         w_grantIdNxt;
    logic                    w_timeoutErrNxt;

    logic                    w_found;
    logic [ID_W-1:0]         w_gnt;
    logic [DATA_WIDTH-1:0]   w_selData;
    logic [4:0]              w_selCfg;
    int                      w_idx;

    // Round-robin search: the first pending requester after the last winner, wrapping around.
    always_comb begin
        w_found   = 1'b0;
        w_gnt     = '0;
        w_selData = '0;
        w_selCfg  = '0;
        w_idx     = 0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            w_idx = (int'(r_last) + k) % NUM_REQ;
            if (!w_found && req_valid[w_idx]) begin
                w_found   = 1'b1;
                w_gnt     = ID_W'(w_idx);
                w_selData = req_data[w_idx*DATA_WIDTH +: DATA_WIDTH];
                w_selCfg  = req_cfg[w_idx*5 +: 5];
            end
        end
    end

    // Next-state and next-output logic; every output is registered from these values.
    always_comb begin
        w_stateNxt      = r_state;
        w_lastNxt       = r_last;
        w_cntNxt        = r_cnt;
        w_reqReadyNxt   = '0;
        w_txValidNxt    = r_txValid;
        w_txDataNxt     = r_txData;
        w_txCfgNxt      = r_txCfg;
        w_grantIdNxt    = r_grantId;
        w_timeoutErrNxt = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_found) begin
                    w_stateNxt    = ST_SEND;
                    w_reqReadyNxt = NUM_REQ'(1) << w_gnt;
                    w_txValidNxt  = 1'b1;
                    w_txDataNxt   = w_selData;
                    w_txCfgNxt    = w_selCfg;
                    w_grantIdNxt  = w_gnt;
                    w_lastNxt     = w_gnt;
                end
            end
            ST_SEND: begin
                if (tx_ready) begin
                    w_txValidNxt = 1'b0;
                    w_cntNxt     = '0;
                    w_stateNxt   = ST_WAIT_BUSY;
                end
            end
            ST_WAIT_BUSY: begin
                if (!tx_ready) begin
                    w_stateNxt = ST_WAIT_DONE;
                end else if (r_cnt == CNT_MAX) begin
                    w_timeoutErrNxt = 1'b1;
                    w_stateNxt      = ST_IDLE;
                end else begin
                    w_cntNxt = r_cnt + CNT_W'(1);
                end
            end
            ST_WAIT_DONE: begin
                if (tx_ready) begin
                    w_stateNxt = ST_IDLE;
                end
            end
            default: begin
                w_stateNxt = ST_IDLE;
            end
        endcase
    end

    // State and output registers; the pointer starts at the top so requester 0 wins first.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state      <= ST_IDLE;
            r_last       <= ID_W'(NUM_REQ - 1);
            r_cnt        <= '0;
            r_reqReady   <= '0;
            r_txValid    <= 1'b0;
            r_txData     <= '0;
            r_txCfg      <= '0;
            r_grantId    <= '0;
            r_busy       <= 1'b0;
            r_timeoutErr <= 1'b0;
        end else begin
            r_state      <= w_stateNxt;
            r_last       <= w_lastNxt;
            r_cnt        <= w_cntNxt;
            r_reqReady   <= w_reqReadyNxt;
            r_txValid    <= w_txValidNxt;
            r_txData     <= w_txDataNxt;
            r_txCfg      <= w_txCfgNxt;
            r_grantId    <= w_grantIdNxt;
            r_busy       <= (w_stateNxt != ST_IDLE);
            r_timeoutErr <= w_timeoutErrNxt;
        end
    end

    assign req_ready   = r_reqReady;
    assign tx_valid    = r_txValid;
    assign tx_data     = r_txData;
    assign tx_mode     = r_txCfg[4];
    assign tx_parity   = r_txCfg[3:2];
    assign tx_stop     = r_txCfg[1:0];
    assign grant_id    = r_grantId;
    assign busy        = r_busy;
    assign timeout_err = r_timeoutErr;

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Testbench for uart_tx_scheduler: the bench plays the uart_tx ready handshake
// and keeps a scoreboard of expected grants (requester, byte, configuration).
module tb_uart_tx_scheduler;

    localparam int NUM_REQ      = 4;
    localparam int DW           = 8;
    localparam int BT           = 4096;
    localparam int GRANT_BUDGET = 20;

    typedef struct packed {
        logic [1:0] id;
        logic [7:0] data;
        logic [4:0] cfg;
    } expGrant_t;

    logic                   clk;
    logic                   reset;
    logic [NUM_REQ-1:0]     req_valid;
    logic [NUM_REQ*DW-1:0]  req_data;
    logic [NUM_REQ*5-1:0]   req_cfg;
    logic [NUM_REQ-1:0]     req_ready;
    logic                   tx_valid;
    logic [DW-1:0]          tx_data;
    logic                   tx_mode;
    logic [1:0]             tx_parity;
    logic [1:0]             tx_stop;
    logic                   tx_ready;
    logic [1:0]             grant_id;
    logic                   busy;
    logic                   timeout_err;

    int        nCompared   = 0;
    int        nMismatched = 0;
    logic [7:0] dataOf[NUM_REQ];
    logic [4:0] cfgOf[NUM_REQ];
    expGrant_t expQ[$];
    expGrant_t curExp;

    uart_tx_scheduler #(
        .NUM_REQ      (NUM_REQ),
        .DATA_WIDTH   (DW),
        .BUSY_TIMEOUT (BT)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .req_valid   (req_valid),
        .req_data    (req_data),
        .req_cfg     (req_cfg),
        .req_ready   (req_ready),
        .tx_valid    (tx_valid),
        .tx_data     (tx_data),
        .tx_mode     (tx_mode),
        .tx_parity   (tx_parity),
        .tx_stop     (tx_stop),
        .tx_ready    (tx_ready),
        .grant_id    (grant_id),
        .busy        (busy),
        .timeout_err (timeout_err)
    );

    // Free-running system clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Safety net so the run always ends even if a handshake never completes.
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation exceeded its time limit");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        nCompared++;
        assert (observed === expected) else begin
            nMismatched++;
            $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic [NUM_REQ-1:0] valid);
        req_valid = valid;
        for (int i = 0; i < NUM_REQ; i++) begin
            req_data[i*DW +: DW] = dataOf[i];
            req_cfg[i*5 +: 5]    = cfgOf[i];
        end
    endtask

    task automatic pushExp(input int id);
        expGrant_t e;
        e.id   = 2'(id);
        e.data = dataOf[id];
        e.cfg  = cfgOf[id];
        expQ.push_back(e);
    endtask

    task automatic checkResetValues(input string tag);
        checkOutput({tag, "_req_ready"}, 32'(req_ready), 32'h0);
        checkOutput({tag, "_tx_valid"}, 32'(tx_valid), 32'h0);
        checkOutput({tag, "_tx_data"}, 32'(tx_data), 32'h0);
        checkOutput({tag, "_tx_cfg"}, 32'({tx_mode, tx_parity, tx_stop}), 32'h0);
        checkOutput({tag, "_grant_id"}, 32'(grant_id), 32'h0);
        checkOutput({tag, "_busy"}, 32'(busy), 32'h0);
        checkOutput({tag, "_timeout_err"}, 32'(timeout_err), 32'h0);
    endtask

    task automatic doReset();
        @(negedge clk);
        reset     = 1'b0;
        tx_ready  = 1'b1;
        applyStimulus('0);
        @(negedge clk);
        checkResetValues("rst");
        @(negedge clk);
        reset = 1'b1;
    endtask

    // Waits (bounded) for a grant pulse, pops the scoreboard and compares the latched frame.
    task automatic serveGrant(input int expLat);
        int cyc;
        cyc = 0;
        while (req_ready == '0 && cyc < GRANT_BUDGET) begin
            @(negedge clk);
            cyc++;
        end
        checkOutput("grant_seen", 32'(req_ready != '0), 32'h1);
        if (expLat >= 0) checkOutput("grant_latency", 32'(cyc), 32'(expLat));
        checkOutput("sb_pending", 32'(expQ.size() != 0), 32'h1);
        if (expQ.size() != 0) curExp = expQ.pop_front();
        else curExp = '0;
        checkOutput("req_ready_onehot", 32'(req_ready), 32'h1 << curExp.id);
        checkOutput("grant_id", 32'(grant_id), 32'(curExp.id));
        checkOutput("tx_data", 32'(tx_data), 32'(curExp.data));
        checkOutput("tx_cfg", 32'({tx_mode, tx_parity, tx_stop}), 32'(curExp.cfg));
        checkOutput("tx_valid_on_grant", 32'(tx_valid), 32'h1);
        checkOutput("busy_on_grant", 32'(busy), 32'h1);
    endtask

    // Plays uart_tx: optional stall in SEND, handoff, nBusy cycles busy, then back to idle.
    task automatic finishFrame(input int sendHold, input int nBusy);
        if (sendHold > 0) begin
            tx_ready = 1'b0;
            repeat (sendHold) begin
                @(negedge clk);
                checkOutput("send_hold_valid", 32'(tx_valid), 32'h1);
                checkOutput("pulse_once", 32'(req_ready), 32'h0);
            end
            tx_ready = 1'b1;
        end
        @(negedge clk);
        checkOutput("handoff_valid_drop", 32'(tx_valid), 32'h0);
        checkOutput("pulse_once", 32'(req_ready), 32'h0);
        checkOutput("busy_in_frame", 32'(busy), 32'h1);
        tx_ready = 1'b0;
        repeat (nBusy) begin
            @(negedge clk);
            checkOutput("hold_data", 32'(tx_data), 32'(curExp.data));
            checkOutput("hold_cfg", 32'({tx_mode, tx_parity, tx_stop}), 32'(curExp.cfg));
            checkOutput("no_pulse_in_frame", 32'(req_ready), 32'h0);
        end
        tx_ready = 1'b1;
    endtask

    // Directed sequence of scenarios.
    initial begin
        int toCycles;
        reset    = 1'b0;
        tx_ready = 1'b1;
        cfgOf[0] = 5'b1_01_00;
        cfgOf[1] = 5'b0_10_01;
        cfgOf[2] = 5'b1_00_10;
        cfgOf[3] = 5'b0_11_11;
        for (int i = 0; i < NUM_REQ; i++) dataOf[i] = 8'h10 + 8'(i);
        applyStimulus('0);
        repeat (2) @(negedge clk);
        $display("[TB] reset values");
        checkResetValues("init");
        reset = 1'b1;

        $display("[TB] single requester");
        dataOf[0] = 8'hA5;
        applyStimulus(4'b0001);
        pushExp(0);
        serveGrant(1);
        dataOf[0] = 8'hFF;
        applyStimulus(4'b0000);
        finishFrame(0, 5);
        repeat (3) begin
            @(negedge clk);
            checkOutput("idle_busy", 32'(busy), 32'h0);
            checkOutput("idle_valid", 32'(tx_valid), 32'h0);
            checkOutput("idle_keep_data", 32'(tx_data), 32'hA5);
            checkOutput("idle_no_pulse", 32'(req_ready), 32'h0);
        end

        $display("[TB] all four requesting");
        doReset();
        for (int i = 0; i < NUM_REQ; i++) dataOf[i] = 8'h10 + 8'(i);
        applyStimulus(4'b1111);
        pushExp(0); pushExp(1); pushExp(2); pushExp(3); pushExp(0);
        for (int f = 0; f < 5; f++) begin
            serveGrant(f == 0 ? 1 : 2);
            if (f == 4) applyStimulus(4'b0000);
            finishFrame(f == 2 ? 2 : 0, 3);
        end

        $display("[TB] fairness");
        doReset();
        applyStimulus(4'b0101);
        pushExp(0); pushExp(2); pushExp(0); pushExp(2);
        for (int f = 0; f < 4; f++) begin
            serveGrant(f == 0 ? 1 : 2);
            if (f == 3) applyStimulus(4'b0000);
            finishFrame(0, 2);
        end

        $display("[TB] late withdrawal");
        doReset();
        applyStimulus(4'b0011);
        pushExp(0);
        serveGrant(1);
        applyStimulus(4'b0000);
        finishFrame(0, 4);
        repeat (5) begin
            @(negedge clk);
            checkOutput("no_regrant", 32'(req_ready), 32'h0);
            checkOutput("no_regrant_busy", 32'(busy), 32'h0);
        end

        $display("[TB] busy timeout");
        applyStimulus(4'b0110);
        pushExp(1);
        serveGrant(1);
        @(negedge clk);
        checkOutput("to_handoff_valid", 32'(tx_valid), 32'h0);
        toCycles = 0;
        while (!timeout_err && toCycles < BT + 100) begin
            @(negedge clk);
            toCycles++;
        end
        checkOutput("timeout_cycles", 32'(toCycles), 32'(BT));
        checkOutput("timeout_busy", 32'(busy), 32'h0);
        pushExp(2);
        serveGrant(1);
        checkOutput("timeout_pulse_width", 32'(timeout_err), 32'h0);
        applyStimulus(4'b0000);
        finishFrame(0, 2);

        $display("[TB] reset mid-frame");
        applyStimulus(4'b1000);
        pushExp(3);
        serveGrant(2);
        applyStimulus(4'b0000);
        @(negedge clk);
        tx_ready = 1'b0;
        @(negedge clk);
        @(negedge clk);
        checkOutput("pre_reset_busy", 32'(busy), 32'h1);
        #2;
        reset = 1'b0;
        #1;
        checkResetValues("async_rst");
        @(negedge clk);
        tx_ready = 1'b1;
        applyStimulus(4'b0110);
        reset = 1'b1;
        pushExp(1);
        serveGrant(1);
        applyStimulus(4'b0000);
        finishFrame(0, 2);
        @(negedge clk);
        checkOutput("sb_drained", 32'(expQ.size()), 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule

// File: doc/uart_tx_scheduler.md
# uart_tx_scheduler

Round-robin scheduler that shares one `uart_tx` transmitter among `NUM_REQ` independent requesters. Each requester supplies a byte and its own frame configuration (mode, parity select, stop select). The block grants one requester at a time, latches that requester's byte and configuration, and drives them into the transmitter's valid/ready port. It holds the configuration stable until the frame completes. It sits between the client logic and `uart_tx`, on the same `clk` as `baud_generator`.

## Interface
- `NUM_REQ`, 4: number of requesters, ≥2.
- `DATA_WIDTH`, 8: frame payload width; must match `uart_tx`.
- `BUSY_TIMEOUT`, 4096: maximum cycles allowed for `tx_ready` to fall after a handoff; ≥2.
- `ID_W`: derived, clog2(`NUM_REQ`), minimum 1.
- `clk`  in  1  system clock; one clock domain.
- `reset`  in  1  asynchronous, active-low reset.
- `req_valid`  in  `NUM_REQ`  bit i = requester i has a byte pending.
- `req_data`  in  `NUM_REQ*DATA_WIDTH`  requester i in bits [i*DATA_WIDTH +: DATA_WIDTH].
- `req_cfg`  in  `NUM_REQ*5`  requester i in bits [i*5 +: 5] = {mode, parity[1:0], stop[1:0]}.
- `req_ready`  out  `NUM_REQ`  one-hot, one-cycle accept pulse.
- `tx_valid`  out  1  to `uart_tx` valid.
- `tx_data`  out  `DATA_WIDTH`  to `uart_tx` p_data_in.
- `tx_mode`  out  1  to `uart_tx` mode.
- `tx_parity`  out  2  to `uart_tx` parity_select.
- `tx_stop`  out  2  to `uart_tx` stop_select.
- `tx_ready`  in  1  from `uart_tx` ready; high = idle.
- `grant_id`  out  `ID_W`  index of the current or last granted requester.
- `busy`  out  1  high whenever state ≠ IDLE.
- `timeout_err`  out  1  one-cycle pulse when the busy timeout fires.

## Operation
- All outputs are registered.
- **Reset values:** state IDLE; `req_ready`=0; `tx_valid`=0; `tx_data`=0; `tx_mode`/`tx_parity`/`tx_stop`=0; `grant_id`=0; `busy`=0; `timeout_err`=0. The round-robin pointer `last`=`NUM_REQ`-1, so requester 0 wins first.
- **IDLE**, with `req_valid`≠0:
  - Select the first set bit searching from `last`+1 upward, wrapping modulo `NUM_REQ`.
  - At the edge: latch that requester's data and cfg into the `tx_*` outputs, set `grant_id`=g, set `last`=g, pulse `req_ready[g]` for exactly one cycle, and go to SEND.
- **IDLE**, with `req_valid`=0: stay in IDLE; `tx_*` outputs keep their last values.
- **SEND:**
  - `tx_valid`=1.
  - On an edge with `tx_ready`=1: drop `tx_valid`, clear the timeout counter, go to WAIT_BUSY.
- **WAIT_BUSY:**
  - `tx_ready`=0 → go to WAIT_DONE.
  - Otherwise increment the counter. On the edge where the counter equals `BUSY_TIMEOUT`-1, pulse `timeout_err` and go to IDLE.
- **WAIT_DONE:** `tx_ready`=1 → go to IDLE.
- **Config stability:** `tx_data`, `tx_mode`, `tx_parity` and `tx_stop` must not change from the grant until the return to IDLE.
- **Requester contract:**
  - Hold `req_valid`, data and cfg stable until `req_ready` is seen.
  - The byte transmitted is the one present on the granting edge.
  - `req_valid` may be dropped, or its data changed, in the cycle `req_ready` is high; no re-grant occurs then, because state ≠ IDLE.
  - A requester that drops `req_valid` before its grant simply loses its turn; no error is raised.
- **Simultaneous requests:** exactly one grant per frame; the others wait. The pointer guarantees each active requester is served within `NUM_REQ` frames.
- **Reset mid-operation:** immediate return to reset values from any state. The in-flight `uart_tx` frame shares the same reset.

## Timing
- **Grant latency:** `req_valid` is sampled high at edge k with state IDLE. Then `req_ready[g]` and `grant_id` are valid in cycle k+1, and `tx_valid` is high in cycle k+1.
- **Handoff:** `tx_valid` stays high for at least one cycle. It drops the cycle after the edge where `tx_valid`∧`tx_ready` is sampled.
- **Minimum gap:** one IDLE cycle between the `tx_ready` rise at the end of a frame and the next `tx_valid`.
- **Timeout:** `timeout_err` rises exactly `BUSY_TIMEOUT` cycles after entry to WAIT_BUSY if `tx_ready` never falls. `busy` drops in the same cycle.
- **Counter:** width clog2(`BUSY_TIMEOUT`); it never wraps, because it is cleared on SEND exit.

## Test plan
- **Single requester:** `req_valid`=0001, data 0xA5, cfg {1,01,00}, real `uart_tx` + `baud_generator`. Expect one `req_ready[0]` pulse, `tx_data`=0xA5, `tx_parity`=01 held through WAIT_DONE, and the serial line carrying 0xA5 with odd/even parity per the cfg.
- **All four requesting:** all `req_valid` high from reset, data 0x10–0x13. Expect grants in order 0,1,2,3, then 0 again. Exactly one `req_ready` bit high per frame, and never two pulses within one frame.
- **Fairness:** requesters 0 and 2 hold `req_valid` continuously. Expect grant sequence 0,2,0,2; requesters 1 and 3 never granted.
- **Timeout:** `tx_ready` tied high. Expect `timeout_err` pulse exactly 4096 cycles after the handoff, `busy`=0 next cycle, and the next grant going to the next requester.
- **Reset mid-frame:** assert `reset`=0 during WAIT_DONE. Expect all outputs at reset values immediately (asynchronously). After release with `req_valid`=0110, the first grant goes to requester 1.
- **Late withdrawal:** requester 1 deasserts `req_valid` while requester 0's frame is in progress. Expect no grant to 1 and no `req_ready[1]` pulse.
